// File: rtl/aligned_word_buffer.sv
// Word buffer between the byte aligner and the memory writer: a DEPTH-entry circular array
// in front of a registered output stage, with early backpressure, last/byte tagging and counters.
module aligned_word_buffer #(
  parameter int unsigned DATA_WIDTH = 256,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned AF_MARGIN  = 2,
  parameter int unsigned CNT_WIDTH  = 32,
  localparam int unsigned BW        = $clog2(DATA_WIDTH / 8) + 1,
  localparam int unsigned LW        = $clog2(DEPTH) + 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  input  logic [BW-1:0]         in_bytes,
  output logic                  almost_full,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic [BW-1:0]         out_bytes,
  output logic [LW-1:0]         level,
  output logic [CNT_WIDTH-1:0]  word_cnt,
  output logic                  done,
  output logic                  overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [BW-1:0] FullBytes = BW'(DATA_WIDTH / 8);
  localparam logic [LW-1:0] AfLevel   = LW'(DEPTH + 1 - AF_MARGIN);
  localparam logic [AW:0]   DepthCnt  = (AW + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_data  [DEPTH];
  logic                  mem_last  [DEPTH];
  logic [BW-1:0]         mem_bytes [DEPTH];

  logic [AW-1:0] rd_ptr_q, wr_ptr_q;
  logic [AW:0]   count_q, count_d;

  logic          pop, ld, arr_empty, take_head, bypass, wr_accept, arr_wr, out_valid_d;
  logic [BW-1:0] in_bytes_fix;
  logic [LW-1:0] level_d;

  always_comb begin
    pop          = out_valid & out_ready;
    ld           = !out_valid | pop;
    arr_empty    = (count_q == '0);
    take_head    = ld & !arr_empty;
    // Bypass only when the array is empty, so FIFO order is never violated.
    bypass       = ld & arr_empty & in_valid;
    wr_accept    = in_valid & ((count_q < DepthCnt) | take_head);
    arr_wr       = wr_accept & !bypass;
    count_d      = count_q + (AW + 1)'(arr_wr) - (AW + 1)'(take_head);
    out_valid_d  = ld ? (take_head | bypass) : 1'b1;
    level_d      = LW'(count_d) + LW'(out_valid_d);
    in_bytes_fix = in_bytes;
    if (!in_last || in_bytes == '0 || in_bytes > FullBytes) begin
      in_bytes_fix = FullBytes;
    end
  end

  // Storage array carries no reset; validity is tracked entirely by the pointers and count.
  always_ff @(posedge clk) begin
    if (arr_wr) begin
      mem_data[wr_ptr_q]  <= in_data;
      mem_last[wr_ptr_q]  <= in_last;
      mem_bytes[wr_ptr_q] <= in_bytes_fix;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_last    <= 1'b0;
      out_bytes   <= '0;
      level       <= '0;
      almost_full <= 1'b0;
      word_cnt    <= '0;
      done        <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      count_q     <= count_d;
      level       <= level_d;
      almost_full <= (level_d >= AfLevel);
      done        <= pop & out_last;
      if (arr_wr) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (take_head) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (pop) begin
        word_cnt <= word_cnt + 1'b1;
      end
      if (in_valid && !wr_accept) begin
        overflow <= 1'b1;
      end
      if (ld) begin
        out_valid <= out_valid_d;
        if (take_head) begin
          out_data  <= mem_data[rd_ptr_q];
          out_last  <= mem_last[rd_ptr_q];
          out_bytes <= mem_bytes[rd_ptr_q];
        end else if (bypass) begin
          out_data  <= in_data;
          out_last  <= in_last;
          out_bytes <= in_bytes_fix;
        end
      end
    end
  end

endmodule

// File: tb/tb_aligned_word_buffer.sv
// Directed and scoreboarded random bench for aligned_word_buffer at its default parameters.
module tb_aligned_word_buffer;

  localparam int unsigned DW = 256;
  localparam int unsigned BW = 6;
  localparam int unsigned LW = 6;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_last;
  logic [BW-1:0] in_bytes;
  logic          almost_full;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic [BW-1:0] out_bytes;
  logic [LW-1:0] level;
  logic [31:0]   word_cnt;
  logic          done;
  logic          overflow;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] exp_q[$];
  int unsigned   popped;

  aligned_word_buffer dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_last    (in_last),
    .in_bytes   (in_bytes),
    .almost_full(almost_full),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .out_bytes  (out_bytes),
    .level      (level),
    .word_cnt   (word_cnt),
    .done       (done),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] mk(input int unsigned v);
    return {8{v}};
  endfunction

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and land 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [DW-1:0] r;
    logic          rdy;
    logic          iv;

    reset = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; in_bytes = '0;
    out_ready = 1'b0;
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_level", level, 0);
    chk("rst_word_cnt", word_cnt, 0);
    chk("rst_almost_full", almost_full, 0);
    chk("rst_overflow", overflow, 0);
    reset = 1'b0;

    // 1: single word through an empty buffer
    in_valid = 1'b1; in_data = {32{8'hA5}}; out_ready = 1'b1;
    step();
    chk("t1_valid", out_valid, 1);
    chk("t1_data", out_data, {32{8'hA5}});
    chk("t1_level1", level, 1);
    chk("t1_cnt0", word_cnt, 0);
    in_valid = 1'b0;
    step();
    chk("t1_popped", out_valid, 0);
    chk("t1_cnt1", word_cnt, 1);
    chk("t1_level0", level, 0);

    // 4: five-word stream with a 7-byte tail; non-last in_bytes must be ignored
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1; in_data = mk(k + 1); in_last = (k == 4);
      in_bytes = (k == 4) ? 6'd7 : 6'd5;
      step();
      chk("t4_data", out_data, mk(k + 1));
      chk("t4_bytes", out_bytes, (k == 4) ? 7 : 32);
      chk("t4_last", out_last, (k == 4));
      chk("t4_done_early", done, 0);
    end
    in_valid = 1'b0; in_last = 1'b0;
    step();
    chk("t4_done", done, 1);
    chk("t4_empty", out_valid, 0);
    step();
    chk("t4_done_pulse", done, 0);

    // out-of-range in_bytes on a last word collapses to a full word
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1; in_data = mk(50 + k); in_last = 1'b1;
      in_bytes = (k == 0) ? 6'd0 : 6'd40;
      step();
      chk("bad_bytes", out_bytes, 32);
      chk("bad_last", out_last, 1);
      in_valid = 1'b0; in_last = 1'b0;
      step();
      chk("bad_done", done, 1);
    end
    chk("cnt_after_streams", word_cnt, 8);

    // 2: fill to DEPTH+1 with consumer stalled, then one write too many
    out_ready = 1'b0; in_bytes = '0;
    for (int i = 0; i < 17; i++) begin
      in_valid = 1'b1; in_data = mk(100 + i);
      step();
      chk("t2_level", level, i + 1);
      chk("t2_af", almost_full, (i + 1 >= 15));
      chk("t2_no_ovf", overflow, 0);
    end
    in_data = mk(999);
    step();
    chk("t2_full_level", level, 17);
    chk("t2_overflow", overflow, 1);
    chk("t2_head", out_data, mk(100));
    in_valid = 1'b0;

    // 3: simultaneous pop and write at full
    exp_q.delete();
    for (int i = 0; i < 17; i++) exp_q.push_back(mk(100 + i));
    out_ready = 1'b1;
    for (int j = 0; j < 20; j++) begin
      chk("t3_order", out_data, exp_q.pop_front());
      in_valid = 1'b1; in_data = mk(200 + j);
      exp_q.push_back(mk(200 + j));
      step();
      chk("t3_level", level, 17);
      chk("t3_ovf_sticky", overflow, 1);
    end
    in_valid = 1'b0;
    chk("t3_cnt", word_cnt, 28);
    chk("t3_af", almost_full, 1);

    // 6: drain to 9 words, then reset mid-pop
    for (int j = 0; j < 8; j++) begin
      chk("t6_drain_order", out_data, exp_q.pop_front());
      step();
    end
    chk("t6_level9", level, 9);
    #2 reset = 1'b1;
    #1;
    chk("t6_valid0", out_valid, 0);
    chk("t6_data0", out_data, 0);
    chk("t6_level0", level, 0);
    chk("t6_cnt0", word_cnt, 0);
    chk("t6_ovf0", overflow, 0);
    chk("t6_af0", almost_full, 0);
    #3 reset = 1'b0;
    out_ready = 1'b0; in_valid = 1'b1; in_data = mk(32'h3C);
    step();
    chk("t6_new_valid", out_valid, 1);
    chk("t6_new_data", out_data, mk(32'h3C));
    in_data = mk(32'h3D);
    step();
    chk("t6_hold_data", out_data, mk(32'h3C));
    chk("t6_level2", level, 2);
    in_valid = 1'b0;

    // 5: random traffic against a queue scoreboard, upstream honouring almost_full
    #2 reset = 1'b1;
    #3 reset = 1'b0;
    step();
    exp_q.delete();
    popped = 0;
    for (int c = 0; c < 3000; c++) begin
      rdy = ($urandom_range(0, 2) != 0);
      iv  = ($urandom_range(0, 3) != 0) && !almost_full;
      out_ready = rdy;
      if (out_valid && rdy) begin
        if (exp_q.size() == 0) chk("t5_unexpected_word", out_valid, 0);
        else chk("t5_order", out_data, exp_q.pop_front());
        popped++;
      end
      for (int b = 0; b < 8; b++) r[b*32 +: 32] = $urandom();
      in_valid = iv; in_data = r;
      if (iv) exp_q.push_back(r);
      step();
      chk("t5_level", level, exp_q.size());
      chk("t5_valid", out_valid, (exp_q.size() != 0));
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 40 && exp_q.size() != 0; c++) begin
      if (out_valid) begin
        chk("t5_drain_order", out_data, exp_q.pop_front());
        popped++;
      end
      step();
    end
    chk("t5_drained", exp_q.size(), 0);
    chk("t5_final_valid", out_valid, 0);
    chk("t5_final_level", level, 0);
    chk("t5_no_overflow", overflow, 0);
    chk("t5_word_cnt", word_cnt, popped);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
